// File: rtl/conv2d_mac_sequencer_if.sv
// Bus bundle for conv2d_mac_sequencer: start/busy/done control,
// image and kernel RAM read ports, result RAM write port.
interface conv2d_mac_sequencer_if #(
    parameter int N = 8,
    parameter int K = 3
);
    localparam int M    = N - K + 1;
    localparam int IA_W = (N * N > 1) ? $clog2(N * N) : 1;
    localparam int KA_W = (K * K > 1) ? $clog2(K * K) : 1;
    localparam int RA_W = (M * M > 1) ? $clog2(M * M) : 1;

    logic              start;
    logic              busy;
    logic              done;
    logic              img_rd_en;
    logic [IA_W-1:0]   img_addr;
    logic [7:0]        img_rdata;
    logic              ker_rd_en;
    logic [KA_W-1:0]   ker_addr;
    logic [7:0]        ker_rdata;
    logic              res_we;
    logic [RA_W-1:0]   res_addr;
    logic signed [15:0] res_wdata;

    // sequencer side
    modport master (
        input  start, img_rdata, ker_rdata,
        output busy, done,
        output img_rd_en, img_addr,
        output ker_rd_en, ker_addr,
        output res_we, res_addr, res_wdata
    );

    // environment side: controller and RAMs
    modport slave (
        output start, img_rdata, ker_rdata,
        input  busy, done,
        input  img_rd_en, img_addr,
        input  ker_rd_en, ker_addr,
        input  res_we, res_addr, res_wdata
    );
endinterface

// File: rtl/conv2d_mac_sequencer.sv
// Time-multiplexed 2D convolution: one 8x8 multiplier and a 32-bit
// accumulator stepped over every output window and kernel tap.
// Ports: clk, rst_n (sync, active-low), bus (master modport):
//   start/busy/done, img_rd_en/img_addr/img_rdata,
//   ker_rd_en/ker_addr/ker_rdata, res_we/res_addr/res_wdata.
module conv2d_mac_sequencer #(
    parameter int N = 8,
    parameter int K = 3
) (
    input logic                    clk,
    input logic                    rst_n,
    conv2d_mac_sequencer_if.master bus
);
    localparam int M    = N - K + 1;
    localparam int IA_W = (N * N > 1) ? $clog2(N * N) : 1;
    localparam int KA_W = (K * K > 1) ? $clog2(K * K) : 1;
    localparam int RA_W = (M * M > 1) ? $clog2(M * M) : 1;
    localparam int CW   = $clog2(N + 1);

    typedef enum logic [2:0] {
        IDLE, RUN, DRAIN, WRITE, DONE
    } state_t;

    state_t          state;
    logic [CW-1:0]   i, j, k, l;
    logic [31:0]     acc;
    logic            pv;
    logic            busy_q, done_q, rd_en_q, we_q;
    logic [IA_W-1:0] img_addr_q;
    logic [KA_W-1:0] ker_addr_q;
    logic [RA_W-1:0] res_addr_q;
    logic [15:0]     wdata_q;

    logic [15:0]     prod;
    logic [31:0]     acc_nxt;
    logic [CW-1:0]   i_nxt, j_nxt, k_nxt, l_nxt;
    logic            last_tap, last_win;

    function automatic logic [IA_W-1:0] img_at(input int r, input int c);
        return IA_W'(r * N + c);
    endfunction

    always_comb begin
        prod     = 16'(bus.img_rdata) * 16'(bus.ker_rdata);
        // pv marks the cycle in which RAM data from last cycle's read is valid
        acc_nxt  = pv ? acc + {16'd0, prod} : acc;
        last_tap = (k == CW'(K - 1)) && (l == CW'(K - 1));
        last_win = (i == CW'(M - 1)) && (j == CW'(M - 1));
        l_nxt    = (l == CW'(K - 1)) ? '0 : l + CW'(1);
        k_nxt    = (l == CW'(K - 1)) ? k + CW'(1) : k;
        j_nxt    = (j == CW'(M - 1)) ? '0 : j + CW'(1);
        i_nxt    = (j == CW'(M - 1)) ? i + CW'(1) : i;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            i          <= '0;
            j          <= '0;
            k          <= '0;
            l          <= '0;
            acc        <= '0;
            pv         <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_en_q    <= 1'b0;
            we_q       <= 1'b0;
            img_addr_q <= '0;
            ker_addr_q <= '0;
            res_addr_q <= '0;
            wdata_q    <= '0;
        end else begin
            pv     <= rd_en_q;
            acc    <= acc_nxt;
            done_q <= 1'b0;
            we_q   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        state      <= RUN;
                        busy_q     <= 1'b1;
                        rd_en_q    <= 1'b1;
                        i          <= '0;
                        j          <= '0;
                        k          <= '0;
                        l          <= '0;
                        acc        <= '0;
                        img_addr_q <= '0;
                        ker_addr_q <= '0;
                    end
                end
                RUN: begin
                    if (last_tap) begin
                        state   <= DRAIN;
                        rd_en_q <= 1'b0;
                    end else begin
                        k          <= k_nxt;
                        l          <= l_nxt;
                        img_addr_q <= img_at(int'(i) + int'(k_nxt),
                                             int'(j) + int'(l_nxt));
                        ker_addr_q <= KA_W'(int'(k_nxt) * K + int'(l_nxt));
                    end
                end
                DRAIN: begin
                    // last product lands now; latch it straight into the write
                    state      <= WRITE;
                    we_q       <= 1'b1;
                    res_addr_q <= RA_W'(int'(i) * M + int'(j));
                    wdata_q    <= acc_nxt[15:0];
                end
                WRITE: begin
                    acc <= '0;
                    k   <= '0;
                    l   <= '0;
                    if (last_win) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        i      <= '0;
                        j      <= '0;
                    end else begin
                        state      <= RUN;
                        rd_en_q    <= 1'b1;
                        i          <= i_nxt;
                        j          <= j_nxt;
                        img_addr_q <= img_at(int'(i_nxt), int'(j_nxt));
                        ker_addr_q <= '0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.img_rd_en = rd_en_q;
    assign bus.ker_rd_en = rd_en_q;
    assign bus.img_addr  = img_addr_q;
    assign bus.ker_addr  = ker_addr_q;
    assign bus.res_we    = we_q;
    assign bus.res_addr  = res_addr_q;
    assign bus.res_wdata = wdata_q;
endmodule

// File: tb/tb_conv2d_mac_sequencer.sv
// Testbench for conv2d_mac_sequencer: RAM models, a direct-sum
// reference, and per-scenario frame checks (8x8/3x3 and 4x4/4x4).
module tb_conv2d_mac_sequencer;
    localparam int N   = 8;
    localparam int K   = 3;
    localparam int M   = N - K + 1;
    localparam int WIN = M * M;
    localparam int LAT = WIN * (K * K + 2);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;

    conv2d_mac_sequencer_if #(.N(8), .K(3)) bus_a ();
    conv2d_mac_sequencer_if #(.N(4), .K(4)) bus_b ();

    conv2d_mac_sequencer #(.N(8), .K(3)) dut_a (
        .clk   (clk),
        .rst_n (rst_a),
        .bus   (bus_a)
    );

    conv2d_mac_sequencer #(.N(4), .K(4)) dut_b (
        .clk   (clk),
        .rst_n (rst_b),
        .bus   (bus_b)
    );

    logic [7:0] img_a [N*N];
    logic [7:0] ker_a [K*K];
    logic [7:0] img_b [16];
    logic [7:0] ker_b [16];

    // synchronous-read RAM models
    always @(posedge clk) begin
        if (bus_a.img_rd_en) bus_a.img_rdata <= img_a[bus_a.img_addr];
        if (bus_a.ker_rd_en) bus_a.ker_rdata <= ker_a[bus_a.ker_addr];
        if (bus_b.img_rd_en) bus_b.img_rdata <= img_b[bus_b.img_addr];
        if (bus_b.ker_rd_en) bus_b.ker_rdata <= ker_b[bus_b.ker_addr];
    end

    int errors = 0;
    int checks = 0;

    int          wr_addr [$];
    logic [15:0] wr_data [$];
    int          done_rel [$];
    time         done_t [$];
    int          busy_cnt;
    int          busy_first;
    int          busy_last;
    int          viol;
    int          post_rst_act;

    // direct convolution sum, truncated to 16 bits
    function automatic logic [15:0] ref_res(input int i, input int j);
        logic [31:0] s;
        s = 0;
        for (int kk = 0; kk < K; kk++)
            for (int ll = 0; ll < K; ll++)
                s += 32'(img_a[(i + kk) * N + j + ll])
                   * 32'(ker_a[kk * K + ll]);
        return s[15:0];
    endfunction

    task automatic fill_random();
        for (int p = 0; p < N * N; p++) img_a[p] = 8'($urandom_range(0, 255));
        for (int p = 0; p < K * K; p++) ker_a[p] = 8'($urandom_range(0, 255));
    endtask

    // starts a frame on dut_a and records activity for len cycles
    task automatic run_a(input int len, input int rst_at, input bit repulse);
        wr_addr.delete();
        wr_data.delete();
        done_rel.delete();
        done_t.delete();
        busy_cnt     = 0;
        busy_first   = -1;
        busy_last    = -1;
        viol         = 0;
        post_rst_act = 0;
        bus_a.start  = 1'b1;
        for (int rel = 1; rel <= len; rel++) begin
            @(negedge clk);
            bus_a.start = 1'b0;
            if (rst_at > 0 && rel == rst_at + 1) rst_a = 1'b1;
            if (bus_a.res_we) begin
                wr_addr.push_back(int'(bus_a.res_addr));
                wr_data.push_back(bus_a.res_wdata);
            end
            if (bus_a.done) begin
                done_rel.push_back(rel);
                done_t.push_back($time);
            end
            if (bus_a.busy) begin
                busy_cnt++;
                if (busy_first < 0) busy_first = rel;
                busy_last = rel;
            end
            if (bus_a.img_rd_en !== bus_a.ker_rd_en) viol++;
            if ((bus_a.img_rd_en || bus_a.res_we) && !bus_a.busy) viol++;
            if (bus_a.img_rd_en && bus_a.res_we) viol++;
            if (bus_a.done && bus_a.busy) viol++;
            if (rst_at > 0 && rel > rst_at &&
                (bus_a.busy || bus_a.done || bus_a.res_we ||
                 bus_a.img_rd_en || bus_a.ker_rd_en))
                post_rst_act++;
            if (repulse && (rel == 5 || rel == 150 || rel == 397))
                bus_a.start = 1'b1;
            if (rst_at > 0 && rel == rst_at) rst_a = 1'b0;
        end
        bus_a.start = 1'b0;
    endtask

    task automatic test_reset();
        rst_a = 1'b0;
        rst_b = 1'b0;
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus_a.busy, bus_a.done, bus_a.img_rd_en,
             bus_a.ker_rd_en, bus_a.res_we} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl_a: got %b want 00000",
                     {bus_a.busy, bus_a.done, bus_a.img_rd_en,
                      bus_a.ker_rd_en, bus_a.res_we});
        end
        checks++;
        if ({bus_a.img_addr, bus_a.res_addr, bus_a.res_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_bus_a: img_addr=%0d res_addr=%0d data=%h",
                     bus_a.img_addr, bus_a.res_addr, bus_a.res_wdata);
        end
        checks++;
        if ({bus_b.busy, bus_b.done, bus_b.img_rd_en, bus_b.res_we} !== 4'b0) begin
            errors++;
            $display("FAIL reset_ctrl_b: got %b want 0000",
                     {bus_b.busy, bus_b.done, bus_b.img_rd_en, bus_b.res_we});
        end
        rst_a = 1'b1;
        rst_b = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_identity();
        logic [15:0] e;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) img_a[r * N + c] = 8'(r * 8 + c);
        for (int p = 0; p < K * K; p++) ker_a[p] = 8'(p == 4 ? 1 : 0);
        run_a(LAT + 4, 0, 1'b0);
        checks++;
        if (wr_addr.size() != WIN) begin
            errors++;
            $display("FAIL ident_count: got %0d want %0d", wr_addr.size(), WIN);
        end
        for (int w = 0; w < wr_addr.size() && w < WIN; w++) begin
            e = 16'(((w / M) + 1) * 8 + (w % M) + 1);
            checks++;
            if (wr_addr[w] !== w || wr_data[w] !== e) begin
                errors++;
                $display("FAIL ident_wr%0d: addr=%0d data=%0d want addr=%0d data=%0d",
                         w, wr_addr[w], wr_data[w], w, e);
            end
        end
        checks++;
        if (done_rel.size() != 1 || done_rel[0] != LAT + 1) begin
            errors++;
            $display("FAIL ident_done: pulses=%0d first=%0d want 1 at %0d",
                     done_rel.size(),
                     done_rel.size() > 0 ? done_rel[0] : -1, LAT + 1);
        end
        checks++;
        if (busy_first != 1 || busy_last != LAT || busy_cnt != LAT) begin
            errors++;
            $display("FAIL ident_busy: first=%0d last=%0d cnt=%0d want 1/%0d/%0d",
                     busy_first, busy_last, busy_cnt, LAT, LAT);
        end
        checks++;
        if (viol != 0) begin
            errors++;
            $display("FAIL ident_protocol: violations=%0d want 0", viol);
        end
    endtask

    task automatic test_saturate_wrap();
        for (int p = 0; p < N * N; p++) img_a[p] = 8'hFF;
        for (int p = 0; p < K * K; p++) ker_a[p] = 8'hFF;
        run_a(LAT + 4, 0, 1'b0);
        checks++;
        if (wr_addr.size() != WIN) begin
            errors++;
            $display("FAIL ff_count: got %0d want %0d", wr_addr.size(), WIN);
        end
        for (int w = 0; w < wr_addr.size() && w < WIN; w++) begin
            checks++;
            if (wr_addr[w] !== w || wr_data[w] !== 16'hEE09) begin
                errors++;
                $display("FAIL ff_wr%0d: addr=%0d data=%h want addr=%0d data=ee09",
                         w, wr_addr[w], wr_data[w], w);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] e;
        for (int f = 0; f < 2; f++) begin
            fill_random();
            run_a(LAT + 4, 0, 1'b0);
            checks++;
            if (wr_addr.size() != WIN || done_rel.size() != 1 || viol != 0) begin
                errors++;
                $display("FAIL rand%0d_frame: writes=%0d dones=%0d viol=%0d",
                         f, wr_addr.size(), done_rel.size(), viol);
            end
            for (int w = 0; w < wr_addr.size() && w < WIN; w++) begin
                e = ref_res(w / M, w % M);
                checks++;
                if (wr_addr[w] !== w || wr_data[w] !== e) begin
                    errors++;
                    $display("FAIL rand%0d_wr%0d: addr=%0d data=%h want %0d/%h",
                             f, w, wr_addr[w], wr_data[w], w, e);
                end
            end
        end
    endtask

    task automatic test_start_repulse();
        logic [15:0] e;
        int bad;
        fill_random();
        run_a(LAT + 14, 0, 1'b1);
        checks++;
        if (wr_addr.size() != WIN || done_rel.size() != 1 ||
            done_rel[0] != LAT + 1 || busy_cnt != LAT) begin
            errors++;
            $display("FAIL repulse_frame: writes=%0d dones=%0d busy=%0d",
                     wr_addr.size(), done_rel.size(), busy_cnt);
        end
        bad = 0;
        for (int w = 0; w < wr_addr.size() && w < WIN; w++) begin
            e = ref_res(w / M, w % M);
            if (wr_addr[w] !== w || wr_data[w] !== e) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL repulse_data: bad_writes=%0d want 0", bad);
        end
    endtask

    task automatic test_mid_reset();
        logic [15:0] e;
        int bad;
        fill_random();
        run_a(120, 100, 1'b0);
        checks++;
        if (wr_addr.size() != 9 || done_rel.size() != 0) begin
            errors++;
            $display("FAIL rst_abort: writes=%0d dones=%0d want 9/0",
                     wr_addr.size(), done_rel.size());
        end
        checks++;
        if (post_rst_act != 0) begin
            errors++;
            $display("FAIL rst_quiet: active_cycles=%0d want 0", post_rst_act);
        end
        run_a(LAT + 4, 0, 1'b0);
        bad = 0;
        for (int w = 0; w < wr_addr.size() && w < WIN; w++) begin
            e = ref_res(w / M, w % M);
            if (wr_addr[w] !== w || wr_data[w] !== e) bad++;
        end
        checks++;
        if (wr_addr.size() != WIN || bad != 0 || done_rel.size() != 1 ||
            done_rel[0] != LAT + 1) begin
            errors++;
            $display("FAIL rst_restart: writes=%0d bad=%0d dones=%0d",
                     wr_addr.size(), bad, done_rel.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] e;
        int bad;
        time t1;
        fill_random();
        run_a(LAT + 1, 0, 1'b0);
        t1 = done_t.size() > 0 ? done_t[0] : 0;
        bad = 0;
        for (int w = 0; w < wr_addr.size() && w < WIN; w++) begin
            e = ref_res(w / M, w % M);
            if (wr_addr[w] !== w || wr_data[w] !== e) bad++;
        end
        checks++;
        if (wr_addr.size() != WIN || bad != 0 || done_t.size() != 1) begin
            errors++;
            $display("FAIL b2b_first: writes=%0d bad=%0d dones=%0d",
                     wr_addr.size(), bad, done_t.size());
        end
        @(negedge clk);
        for (int p = 0; p < K * K; p++) ker_a[p] = 8'($urandom_range(0, 255));
        run_a(LAT + 4, 0, 1'b0);
        bad = 0;
        for (int w = 0; w < wr_addr.size() && w < WIN; w++) begin
            e = ref_res(w / M, w % M);
            if (wr_addr[w] !== w || wr_data[w] !== e) bad++;
        end
        checks++;
        if (wr_addr.size() != WIN || bad != 0) begin
            errors++;
            $display("FAIL b2b_second: writes=%0d bad=%0d", wr_addr.size(), bad);
        end
        checks++;
        if (done_t.size() != 1 || done_t[0] - t1 != 398 * 10) begin
            errors++;
            $display("FAIL b2b_gap: dones=%0d gap=%0t want %0d",
                     done_t.size(), done_t.size() > 0 ? done_t[0] - t1 : 0,
                     398 * 10);
        end
    endtask

    task automatic test_degenerate();
        int nwr;
        int waddr;
        logic [15:0] wdat;
        int drel;
        int ndone;
        for (int p = 0; p < 16; p++) begin
            img_b[p] = 8'd1;
            ker_b[p] = 8'(p);
        end
        nwr = 0;
        waddr = -1;
        wdat = '0;
        drel = -1;
        ndone = 0;
        bus_b.start = 1'b1;
        for (int rel = 1; rel <= 25; rel++) begin
            @(negedge clk);
            bus_b.start = 1'b0;
            if (bus_b.res_we) begin
                nwr++;
                waddr = int'(bus_b.res_addr);
                wdat = bus_b.res_wdata;
            end
            if (bus_b.done) begin
                ndone++;
                drel = rel;
            end
        end
        checks++;
        if (nwr != 1 || waddr != 0 || wdat !== 16'd120) begin
            errors++;
            $display("FAIL degen_write: n=%0d addr=%0d data=%0d want 1/0/120",
                     nwr, waddr, wdat);
        end
        checks++;
        if (ndone != 1 || drel != 19) begin
            errors++;
            $display("FAIL degen_done: pulses=%0d cycle=%0d want 1 at 19",
                     ndone, drel);
        end
    endtask

    initial begin
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
        rst_a = 1'b0;
        rst_b = 1'b0;
        test_reset();
        test_identity();
        test_saturate_wrap();
        test_random();
        test_start_repulse();
        test_mid_reset();
        test_back_to_back();
        test_degenerate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
